mcu_write_scheduler: RTL and testbench
======================================

# mcu_write_scheduler

Sequences writes of decoded 8x8 blocks into the YCbCr channel buffer for 4:2:0 MCUs. Accepts a tagged block stream from the upstream IDCT/upsample stage, issues the buffer's `wr_en`/`ch` in MCU order (Y0..Y3, Cb, Cr), and throttles the stream so Cb/Cr are never overwritten while the buffer is still draining the previous MCU. Counts MCUs per frame and flags completion and ordering errors.

## Interface
- `MCU_W`, 16, width of MCU count
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: frame start pulse; sampled only in S_IDLE
- `num_mcu` in MCU_W: MCUs in frame; latched on accepted `start`
- `blk_valid` in 1: upstream block present
- `blk_ch` in 2: upstream tag, 0=Y, 1=Cb, 2=Cr
- `blk_ready` out 1: scheduler accepts block this cycle
- `wr_en` out 1: channel buffer write strobe
- `ch` out `$clog2(`CH+1)`: channel buffer channel select
- `drain_active` out 1: buffer is emitting pixels (mirror of buffer count>0)
- `busy` out 1: frame in progress
- `frame_done` out 1: one-cycle pulse at frame end
- `seq_err` out 1: sticky tag-mismatch flag

## Operation
- FSM states: S_IDLE, S_Y, S_CB, S_CR.
- S_IDLE: `blk_ready`=0. `start`=1 latches `num_mcu` into `mcu_left`, clears `seq_err`, goes to S_Y (`num_mcu`=0: no transition, `frame_done` pulses next cycle).
- S_Y: `blk_ready`=1; `ch`=0; 2-bit `y_idx` increments per accepted block; after 4th (y_idx wraps 3->0) go to S_CB.
- S_CB: `blk_ready`=(drain_cnt==0); `ch`=1; on accept go to S_CR.
- S_CR: `blk_ready`=1; `ch`=2; on accept `drain_cnt`<=4, `mcu_left`<=mcu_left-1; go to S_Y if mcu_left>1, else stay S_CR with `blk_ready`=0 (flag `last`) until drain completes, then S_IDLE.
- `wr_en` = `blk_valid` & `blk_ready`.
- `drain_cnt` (3 bits) decrements each cycle while >0; `drain_active` = (drain_cnt!=0). Y writes for MCU n+1 permitted during drain of MCU n (buffer reads y[k] before it is rewritten).
- Accepted block with `blk_ch` != expected: write still issued with expected `ch`; `seq_err`<=1, held until next accepted `start`.
- `frame_done`: pulses the cycle `drain_cnt` goes 1->0 with `last` set; `busy`=0 from that cycle.
- `start` while busy ignored.

## Timing
- Reset values: `blk_ready`=0, `wr_en`=0, `ch`=0, `drain_active`=0, `busy`=0, `frame_done`=0, `seq_err`=0; state S_IDLE, all counters 0.
- `blk_ready` depends only on registered state; no comb path from `blk_valid` to `blk_ready`.
- Best-case MCU: 6 cycles back-to-back; Cb of MCU n+1 stalls until drain of MCU n ends (drain 4 cycles, so no stall if Y takes >=4 cycles).
- Last Cr accept at cycle t -> `frame_done` at t+4.
- `rst` mid-frame: immediate return to reset values; channel buffer shares `rst`.

## Configuration
- `MCU_SCHED_STATS_EN` defined: adds output `stall_cycles` [31:0], counts cycles with `blk_valid`=1 & `blk_ready`=0 while busy; cleared on accepted `start` and reset.
- Undefined: port and counter absent; other behaviour identical.

## Structure
- Add to `sys_defs.svh`: `typedef enum logic [1:0] {S_IDLE,S_Y,S_CB,S_CR} SCHED_STATE`, `` `MCU_BLOCKS`` = 6, `` `Y_PER_MCU`` = 4, channel tag constants Y/CB/CR = 0/1/2. Reuse `` `CH``.
- Single module; no sub-module.

## Test plan
- Reset, start num_mcu=1, valid held with correct tags -> wr_en 6 cycles, ch 0,0,0,0,1,2; frame_done 4 cycles after Cr; busy drops same cycle.
- num_mcu=2, continuous valid -> MCU2 Y0..Y3 accepted during drain, Cb accepted without stall; frame_done at Cr2+4.
- num_mcu=2, Y of MCU2 delivered in 2 cycles then Cb valid -> blk_ready low 2 cycles for Cb (stall_cycles=2 with STATS_EN).
- Wrong tag (Cb in Y slot) -> write with ch=0, seq_err=1, cleared by next start.
- start with num_mcu=0 -> no wr_en, frame_done 1 cycle after start.
- rst asserted mid-S_CB -> all outputs zero immediately; new start runs a clean MCU.

Source files
------------

// File: rtl/mcu_write_scheduler_pkg.sv
// Shared definitions for the 4:2:0 MCU write scheduler: FSM state
// encoding, MCU geometry, channel tags and drain timing.
package mcu_write_scheduler_pkg;

  // Number of the highest channel index (Y=0, Cb=1, Cr=2).
  localparam int CH         = 2;
  localparam int CH_W       = $clog2(CH + 1);
  localparam int MCU_BLOCKS = 6;
  localparam int Y_PER_MCU  = 4;

  // Upstream block tags; they share the encoding of the buffer channel select.
  localparam logic [CH_W-1:0] TAG_Y  = 2'd0;
  localparam logic [CH_W-1:0] TAG_CB = 2'd1;
  localparam logic [CH_W-1:0] TAG_CR = 2'd2;

  // The buffer needs four cycles to drain the chroma of an MCU.
  localparam int              DRAIN_W    = 3;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_Y    = 2'd1,
    S_CB   = 2'd2,
    S_CR   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mcu_write_scheduler.sv
// MCU write scheduler: accepts a tagged 8x8 block stream, issues channel
// buffer writes in Y0..Y3, Cb, Cr order, and holds off the next Cb until the
// buffer has finished draining the previous MCU.
// Optional feature macro: MCU_SCHED_STATS_EN adds the stall_cycles_o counter.
module mcu_write_scheduler
  import mcu_write_scheduler_pkg::*;
#(
  parameter int MCU_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [MCU_W-1:0] num_mcu_i,
  input  logic             blk_valid_i,
  input  logic [1:0]       blk_ch_i,
  output logic             blk_ready_o,
  output logic             wr_en_o,
  output logic [CH_W-1:0]  ch_o,
  output logic             drain_active_o,
  output logic             busy_o,
  output logic             frame_done_o,
`ifdef MCU_SCHED_STATS_EN
  output logic [31:0]      stall_cycles_o,
`endif
  output logic             seq_err_o
);

  sched_state_e         state_q, state_d;
  logic [1:0]           y_idx_q, y_idx_d;
  logic [MCU_W-1:0]     mcu_left_q, mcu_left_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 last_q, last_d;
  logic                 seq_err_q, seq_err_d;
  logic                 zero_done_q, zero_done_d;
  logic                 accept;
  logic [CH_W-1:0]      exp_tag;

  // Ready and channel select come from registered state only, so there is
  // no combinational path from blk_valid_i back to blk_ready_o.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // otherwise a branch that skips the assignment infers a latch.
    blk_ready_o = 1'b0;
    exp_tag     = TAG_Y;
    unique case (state_q)
      S_IDLE: begin
        blk_ready_o = 1'b0;
        exp_tag     = TAG_Y;
      end
      S_Y: begin
        blk_ready_o = 1'b1;
        exp_tag     = TAG_Y;
      end
      S_CB: begin
        blk_ready_o = (drain_cnt_q == '0);
        exp_tag     = TAG_CB;
      end
      S_CR: begin
        blk_ready_o = ~last_q;
        exp_tag     = TAG_CR;
      end
      default: begin
        blk_ready_o = 1'b0;
        exp_tag     = TAG_Y;
      end
    endcase
  end

  assign accept         = blk_valid_i & blk_ready_o;
  assign wr_en_o        = accept;
  assign ch_o           = exp_tag;
  assign drain_active_o = (drain_cnt_q != '0);
  assign seq_err_o      = seq_err_q;
  // End of a real frame is the last drain cycle; an empty frame ends the
  // cycle after its start.
  assign frame_done_o   = zero_done_q | (last_q & (drain_cnt_q == 3'd1));
  assign busy_o         = (state_q != S_IDLE) & ~frame_done_o;

  // Next-state logic: MCU sequencing, drain countdown and error tracking.
  always_comb begin
    state_d     = state_q;
    y_idx_d     = y_idx_q;
    mcu_left_d  = mcu_left_q;
    drain_cnt_d = (drain_cnt_q != '0) ? drain_cnt_q - 3'd1 : drain_cnt_q;
    last_d      = last_q;
    seq_err_d   = seq_err_q;
    zero_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          seq_err_d  = 1'b0;
          mcu_left_d = num_mcu_i;
          if (num_mcu_i == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = S_Y;
          end
        end
      end
      S_Y: begin
        if (accept) begin
          y_idx_d = y_idx_q + 2'd1;
          if (y_idx_q == 2'(Y_PER_MCU - 1)) begin
            state_d = S_CB;
          end
        end
      end
      S_CB: begin
        if (accept) begin
          state_d = S_CR;
        end
      end
      S_CR: begin
        if (accept) begin
          drain_cnt_d = DRAIN_LOAD;
          mcu_left_d  = mcu_left_q - MCU_W'(1);
          if (mcu_left_q > MCU_W'(1)) begin
            state_d = S_Y;
          end else begin
            last_d = 1'b1;
          end
        end
        // Frame closes on the final drain cycle of the last MCU.
        if (last_q && (drain_cnt_q == 3'd1)) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A mistagged block is still written to the expected channel.
    if (accept && (blk_ch_i != exp_tag)) begin
      seq_err_d = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      y_idx_q     <= '0;
      mcu_left_q  <= '0;
      drain_cnt_q <= '0;
      last_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q     <= state_d;
      y_idx_q     <= y_idx_d;
      mcu_left_q  <= mcu_left_d;
      drain_cnt_q <= drain_cnt_d;
      last_q      <= last_d;
      seq_err_q   <= seq_err_d;
      zero_done_q <= zero_done_d;
    end
  end

`ifdef MCU_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter: cycles a block waits while a frame is in progress.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start_i) begin
      stall_d = '0;
    end else if (busy_o && blk_valid_i && !blk_ready_o) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mcu_write_scheduler.sv
// Self-checking bench for mcu_write_scheduler: a scoreboard queue holds the
// expected channel of every block offered; each observed write pops it.
module tb_mcu_write_scheduler;
  import mcu_write_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      num_mcu;
  logic             blk_valid;
  logic [1:0]       blk_ch;
  logic             blk_ready;
  logic             wr_en;
  logic [CH_W-1:0]  ch;
  logic             drain_active;
  logic             busy;
  logic             frame_done;
  logic             seq_err;
`ifdef MCU_SCHED_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  mcu_write_scheduler #(.MCU_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .num_mcu_i      (num_mcu),
    .blk_valid_i    (blk_valid),
    .blk_ch_i       (blk_ch),
    .blk_ready_o    (blk_ready),
    .wr_en_o        (wr_en),
    .ch_o           (ch),
    .drain_active_o (drain_active),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
`ifdef MCU_SCHED_STATS_EN
    .stall_cycles_o (stall_cycles),
`endif
    .seq_err_o      (seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int n_wr = 0;
  int last_cr_cyc = -1;
  int done_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected channel.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      check("wr_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("wr_ch", ch, exp_q.pop_front());
      if (ch == TAG_CR) last_cr_cyc = cyc;
    end
    if (frame_done) begin
      done_cyc = cyc;
      check("busy_at_done", busy, 0);
    end
  end

  // All tasks start and end at posedge+1.
  task automatic start_frame(input int n);
    start   = 1'b1;
    num_mcu = 16'(n);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic send_block(input logic [1:0] tag, input int exp_ch, output int acc);
    exp_q.push_back(exp_ch);
    blk_valid = 1'b1;
    blk_ch    = tag;
    acc       = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("ready_timeout", blk_ready, 1);
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  task automatic send_mcu(output int first_acc, output int last_acc);
    int a;
    for (int i = 0; i < Y_PER_MCU; i++) begin
      send_block(TAG_Y, 0, a);
      if (i == 0) first_acc = a;
    end
    send_block(TAG_CB, 1, a);
    send_block(TAG_CR, 2, a);
    last_acc = a;
  endtask

  task automatic wait_done(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int f0, f1, l0, l1, w0, a;
    rst = 1'b1; start = 1'b0; num_mcu = '0; blk_valid = 1'b0; blk_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", blk_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ch", ch, 0);
    check("rst_drain", drain_active, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_seq_err", seq_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // One MCU, correct tags.
    w0 = n_wr;
    start_frame(1);
    @(negedge clk);
    check("m1_busy", busy, 1);
    @(posedge clk); #1;
    send_mcu(f0, l0);
    check("m1_span", l0 - f0, MCU_BLOCKS - 1);
    // Block offered during the final drain must be held off.
    blk_valid = 1'b1; blk_ch = TAG_Y;
    @(negedge clk);
    check("m1_wait_ready", blk_ready, 0);
    check("m1_wait_wr", wr_en, 0);
    check("m1_drain_active", drain_active, 1);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    wait_done(20);
    check("m1_done_lat", done_cyc - last_cr_cyc, 4);
    check("m1_idle_busy", busy, 0);
    check("m1_idle_ready", blk_ready, 0);
    check("m1_idle_drain", drain_active, 0);
    check("m1_writes", n_wr - w0, MCU_BLOCKS);
    check("m1_sb_empty", exp_q.size(), 0);
`ifdef MCU_SCHED_STATS_EN
    check("m1_stalls", stall_cycles, 1);
`endif

    // Two MCUs, continuous stream: MCU2 Y overlaps drain, Cb does not stall.
    w0 = n_wr;
    start_frame(2);
    send_mcu(f0, l0);
    send_mcu(f1, l1);
    check("m2_y_overlap", f1 - l0, 1);
    check("m2_span", l1 - f0, 2 * MCU_BLOCKS - 1);
    wait_done(20);
    check("m2_done_lat", done_cyc - last_cr_cyc, 4);
    check("m2_writes", n_wr - w0, 2 * MCU_BLOCKS);
`ifdef MCU_SCHED_STATS_EN
    check("m2_stalls", stall_cycles, 0);
`endif

    // Wrong tag in a Y slot: written as Y, sticky error until next start.
    start_frame(1);
    send_block(TAG_CB, 0, a);
    check("tag_err_set", seq_err, 1);
    for (int i = 1; i < Y_PER_MCU; i++) send_block(TAG_Y, 0, a);
    send_block(TAG_CB, 1, a);
    send_block(TAG_CR, 2, a);
    wait_done(20);
    check("tag_err_sticky", seq_err, 1);
    start_frame(1);
    check("tag_err_clear", seq_err, 0);
    send_mcu(f0, l0);
    wait_done(20);
    check("tag_err_clean", seq_err, 0);

    // Empty frame: no writes, done the cycle after start.
    w0 = n_wr;
    start   = 1'b1;
    num_mcu = '0;
    @(negedge clk);
    check("zero_done_early", frame_done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", frame_done, 1);
    check("zero_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_done_pulse", frame_done, 0);
    check("zero_writes", n_wr - w0, 0);
    @(posedge clk); #1;

    // Reset while waiting in the Cb slot, then a clean MCU.
    start_frame(1);
    for (int i = 0; i < Y_PER_MCU; i++) send_block(TAG_Y, 0, a);
    check("cb_slot_ch", ch, 1);
    blk_valid = 1'b1; blk_ch = TAG_CB;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", blk_ready, 0);
    check("mid_rst_wr", wr_en, 0);
    check("mid_rst_ch", ch, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drain", drain_active, 0);
    blk_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    w0 = n_wr;
    start_frame(1);
    send_mcu(f0, l0);
    wait_done(20);
    check("post_rst_writes", n_wr - w0, MCU_BLOCKS);
    check("post_rst_done_lat", done_cyc - last_cr_cyc, 4);
    check("post_rst_seq_err", seq_err, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
